// File: rtl/cache_pkg.sv
// Shared definitions for the cache control block: maintenance op and
// command encodings, register word offsets and the channel FSM states.
package cache_pkg;

    // Maintenance op as written to CMD[9:8]: bit0 invalidate, bit1 writeback.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INV  = 2'd1,
        OP_WB   = 2'd2,
        OP_BOTH = 2'd3
    } cache_op_e;

    // Command codes presented to a cache channel on cmd.
    typedef enum logic [2:0] {
        cache_io_cmd_none    = 3'd0,
        cache_io_cmd_clear   = 3'd1,
        cache_io_cmd_wb      = 3'd2,
        cache_io_cmd_wbclear = 3'd3
    } cache_cmd_e;

    // Per-channel handshake state.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_WAIT = 1'b1
    } chan_state_e;

    // Register word indices (byte address bits [7:2]).
    localparam logic [5:0] REG_CTRL        = 6'd0;
    localparam logic [5:0] REG_CMD         = 6'd1;
    localparam logic [5:0] REG_STATUS      = 6'd2;
    localparam logic [5:0] REG_REGION_BASE = 6'd4;

    // Field positions inside the registers.
    localparam int CTRL_TOP_IO_BIT    = 8;
    localparam int CTRL_REGION_EN_LSB = 16;
    localparam int CMD_OP_LSB         = 8;
    localparam int STATUS_ERR_LSB     = 8;

    // Map a non-zero op onto the command code driven to the cache.
    function automatic cache_cmd_e op_to_cmd(input logic [1:0] op);
        case (op)
            OP_INV:  op_to_cmd = cache_io_cmd_clear;
            OP_WB:   op_to_cmd = cache_io_cmd_wb;
            OP_BOTH: op_to_cmd = cache_io_cmd_wbclear;
            default: op_to_cmd = cache_io_cmd_none;
        endcase
    endfunction

endpackage

// File: rtl/cache_cmd_chan.sv
// One maintenance-command channel: latches a request into cmd/cmd_valid and
// holds it until the cache accepts it.
//
// Handshake: cmd_valid/cmd_ready follow strict valid/ready rules. Once
// cmd_valid rises, cmd stays stable and cmd_valid stays high until the edge
// where cmd_valid & cmd_ready are both 1; cmd_ready while cmd_valid is low
// has no effect.
module cache_cmd_chan
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rest,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic        cmd_ready,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    output logic        busy,
    output logic        done_pulse,
    output logic        err_pulse,
    output chan_state_e state
);

    // Channel FSM with registered cmd/cmd_valid.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state     <= CH_IDLE;
            cmd       <= cache_io_cmd_none;
            cmd_valid <= 1'b0;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (req) begin
                        cmd       <= op_to_cmd(op);
                        cmd_valid <= 1'b1;
                        state     <= CH_WAIT;
                    end
                end
                CH_WAIT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= CH_IDLE;
                    end
                end
                default: state <= CH_IDLE;
            endcase
        end
    end

    assign busy       = (state != CH_IDLE);
    // Completion is the accepting edge itself; STATUS captures it there.
    assign done_pulse = (state == CH_WAIT) & cmd_ready;
    // A request arriving while a command is outstanding is dropped.
    assign err_pulse  = req & (state != CH_IDLE);

endmodule

// File: rtl/cache_region_ctr.sv
// Memory-mapped cache control: IO region table, per-channel cache enables,
// maintenance command issue and sticky done/err status.
module cache_region_ctr
    import cache_pkg::*;
#(
    parameter int REGION_NUM = 4,
    parameter int GRAN_BITS  = 10,
    parameter int CMD_CH     = 2
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic [31:0]           s0_address,
    input  logic [3:0]            s0_byteEnable,
    input  logic                  s0_read,
    output logic [31:0]           s0_readData,
    input  logic                  s0_write,
    input  logic [31:0]           s0_writeData,
    output logic                  s0_waitRequest,
    output logic                  s0_readDataValid,
    input  logic [32*CMD_CH-1:0]  look_addr,
    output logic [CMD_CH-1:0]     isIOAddrBlock,
    output logic [CMD_CH-1:0]     isEnableCache,
    output logic [3*CMD_CH-1:0]   cmd,
    output logic [CMD_CH-1:0]     cmd_valid,
    input  logic [CMD_CH-1:0]     cmd_ready
);

    localparam int RW = 32 - GRAN_BITS;

    logic [5:0]            widx;
    logic                  wr_ctrl, wr_cmd, wr_status;
    logic [CMD_CH-1:0]     en_q;
    logic                  top_io_q;
    logic [REGION_NUM-1:0] reg_en_q;
    logic [RW-1:0]         low_q  [REGION_NUM];
    logic [RW-1:0]         high_q [REGION_NUM];
    logic [CMD_CH-1:0]     done_q, err_q;
    logic [CMD_CH-1:0]     busy_v, done_v, err_v, req_v, chan_state_dbg;
    logic [1:0]            chan_op [CMD_CH];
    logic [31:0]           rd_mux;
    logic                  unused_ok;

    assign widx           = s0_address[7:2];
    assign wr_ctrl        = s0_write && (widx == REG_CTRL);
    assign wr_cmd         = s0_write && (widx == REG_CMD);
    assign wr_status      = s0_write && (widx == REG_STATUS);
    assign s0_waitRequest = 1'b0;
    assign isEnableCache  = en_q;

    // Per-channel request op: explicit CMD write ORed with the invalidate
    // that an enable 1->0 transition owes the cache.
    always_comb begin
        for (int c = 0; c < CMD_CH; c++) begin
            chan_op[c] = OP_NONE;
            if (wr_cmd && s0_writeData[c])
                chan_op[c] = chan_op[c] | s0_writeData[CMD_OP_LSB +: 2];
            if (wr_ctrl && en_q[c] && !s0_writeData[c])
                chan_op[c] = chan_op[c] | OP_INV;
            req_v[c] = |chan_op[c];
        end
    end

    // Configuration registers: CTRL fields and region boundaries.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            en_q     <= '1;
            top_io_q <= 1'b1;
            reg_en_q <= '0;
            for (int i = 0; i < REGION_NUM; i++) begin
                low_q[i]  <= '1;
                high_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                en_q     <= s0_writeData[CMD_CH-1:0];
                top_io_q <= s0_writeData[CTRL_TOP_IO_BIT];
                reg_en_q <= s0_writeData[CTRL_REGION_EN_LSB +: REGION_NUM];
            end
            for (int i = 0; i < REGION_NUM; i++) begin
                if (s0_write && (widx == REG_REGION_BASE + 6'(2*i)))
                    low_q[i] <= s0_writeData[31:GRAN_BITS];
                if (s0_write && (widx == REG_REGION_BASE + 6'(2*i + 1)))
                    high_q[i] <= s0_writeData[31:GRAN_BITS];
            end
        end
    end

    // Sticky done/err; a same-cycle set beats the write-1-to-clear.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            done_q <= '0;
            err_q  <= '0;
        end else begin
            done_q <= (done_q & ~(wr_status ? s0_writeData[CMD_CH-1:0] : '0)) | done_v;
            err_q  <= (err_q & ~(wr_status ? s0_writeData[STATUS_ERR_LSB +: CMD_CH] : '0)) | err_v;
        end
    end

    // Read mux; unmapped offsets fall through to zero.
    always_comb begin
        rd_mux = '0;
        case (widx)
            REG_CTRL: begin
                rd_mux[CMD_CH-1:0]                        = en_q;
                rd_mux[CTRL_TOP_IO_BIT]                   = top_io_q;
                rd_mux[CTRL_REGION_EN_LSB +: REGION_NUM]  = reg_en_q;
            end
            REG_CMD:    rd_mux[CMD_CH-1:0] = busy_v;
            REG_STATUS: begin
                rd_mux[CMD_CH-1:0]               = done_q;
                rd_mux[STATUS_ERR_LSB +: CMD_CH] = err_q;
            end
            default: rd_mux = '0;
        endcase
        for (int i = 0; i < REGION_NUM; i++) begin
            if (widx == REG_REGION_BASE + 6'(2*i))
                rd_mux = {low_q[i], {GRAN_BITS{1'b0}}};
            if (widx == REG_REGION_BASE + 6'(2*i + 1))
                rd_mux = {high_q[i], {GRAN_BITS{1'b0}}};
        end
    end

    // Registered read response, one cycle after the strobe.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            s0_readData      <= '0;
            s0_readDataValid <= 1'b0;
        end else begin
            s0_readDataValid <= s0_read;
            if (s0_read)
                s0_readData <= rd_mux;
        end
    end

    for (genvar c = 0; c < CMD_CH; c++) begin : g_ch
        logic [31:0] addr;
        logic        hit;
        chan_state_e st;

        assign addr = look_addr[32*c +: 32];

        // Unsigned region compare against the stored granule boundaries.
        always_comb begin
            hit = top_io_q & addr[31];
            for (int i = 0; i < REGION_NUM; i++) begin
                if (reg_en_q[i] && (addr[31:GRAN_BITS] >= low_q[i])
                                && (addr[31:GRAN_BITS] <= high_q[i]))
                    hit = 1'b1;
            end
        end

        assign isIOAddrBlock[c]  = hit;
        assign chan_state_dbg[c] = st;

        cache_cmd_chan u_chan (
            .clk        (clk),
            .rest       (rest),
            .req        (req_v[c]),
            .op         (chan_op[c]),
            .cmd_ready  (cmd_ready[c]),
            .cmd        (cmd[3*c +: 3]),
            .cmd_valid  (cmd_valid[c]),
            .busy       (busy_v[c]),
            .done_pulse (done_v[c]),
            .err_pulse  (err_v[c]),
            .state      (st)
        );
    end

    // Full-word bus and partially decoded address/data bits.
    assign unused_ok = ^{s0_byteEnable, s0_address, s0_writeData, look_addr, chan_state_dbg};

endmodule

// File: tb/tb_cache_region_ctr.sv
// Directed bench for cache_region_ctr with CMD_CH=2, REGION_NUM=4, GRAN_BITS=10.
module tb_cache_region_ctr;

    logic        clk = 1'b0;
    logic        rest;
    logic [31:0] s0_address;
    logic [3:0]  s0_byteEnable;
    logic        s0_read;
    logic [31:0] s0_readData;
    logic        s0_write;
    logic [31:0] s0_writeData;
    logic        s0_waitRequest;
    logic        s0_readDataValid;
    logic [63:0] look_addr;
    logic [1:0]  isIOAddrBlock;
    logic [1:0]  isEnableCache;
    logic [5:0]  cmd;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic        rv;

    cache_region_ctr #(.REGION_NUM(4), .GRAN_BITS(10), .CMD_CH(2)) dut (
        .clk              (clk),
        .rest             (rest),
        .s0_address       (s0_address),
        .s0_byteEnable    (s0_byteEnable),
        .s0_read          (s0_read),
        .s0_readData      (s0_readData),
        .s0_write         (s0_write),
        .s0_writeData     (s0_writeData),
        .s0_waitRequest   (s0_waitRequest),
        .s0_readDataValid (s0_readDataValid),
        .look_addr        (look_addr),
        .isIOAddrBlock    (isIOAddrBlock),
        .isEnableCache    (isEnableCache),
        .cmd              (cmd),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, results are sampled
    // on the following falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        s0_address   = a;
        s0_writeData = d;
        s0_write     = 1'b1;
        @(negedge clk);
        s0_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        s0_address = a;
        s0_read    = 1'b1;
        @(negedge clk);
        s0_read    = 1'b0;
        d = s0_readData;
        v = s0_readDataValid;
    endtask

    task automatic set_look(input logic [31:0] a);
        look_addr = {a, a};
        #1;
    endtask

    task automatic test_reset;
        rest = 1'b0; s0_address = '0; s0_byteEnable = 4'hf; s0_read = 1'b0;
        s0_write = 1'b0; s0_writeData = '0; look_addr = '0; cmd_ready = '0;
        repeat (3) @(negedge clk);
        rest = 1'b1;
        checks++; if (cmd_valid !== 2'b00) begin errors++; $display("FAIL rst_cmd_valid got %b exp 00", cmd_valid); end
        checks++; if (cmd !== 6'd0) begin errors++; $display("FAIL rst_cmd got %h exp 0", cmd); end
        checks++; if (isEnableCache !== 2'b11) begin errors++; $display("FAIL rst_enable got %b exp 11", isEnableCache); end
        checks++; if (s0_readDataValid !== 1'b0 || s0_readData !== 32'h0) begin errors++; $display("FAIL rst_rdata got %b/%h exp 0/0", s0_readDataValid, s0_readData); end
        checks++; if (s0_waitRequest !== 1'b0) begin errors++; $display("FAIL waitreq got %b exp 0", s0_waitRequest); end
        // back-to-back reads: CTRL then LOW_0
        @(negedge clk); s0_address = 32'h00; s0_read = 1'b1;
        @(negedge clk);
        checks++; if (s0_readDataValid !== 1'b1 || s0_readData !== 32'h0000_0103) begin errors++; $display("FAIL ctrl_reset got %b/%h exp 1/00000103", s0_readDataValid, s0_readData); end
        s0_address = 32'h10;
        @(negedge clk); s0_read = 1'b0;
        checks++; if (s0_readDataValid !== 1'b1 || s0_readData !== 32'hFFFF_FC00) begin errors++; $display("FAIL low0_reset got %b/%h exp 1/fffffc00", s0_readDataValid, s0_readData); end
        @(negedge clk);
        checks++; if (s0_readDataValid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got %b exp 0", s0_readDataValid); end
        bus_read(32'h14, rd, rv);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL high0_reset got %b/%h exp 1/0", rv, rd); end
        bus_read(32'h0C, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL hole_0c got %h exp 0", rd); end
        set_look(32'h8000_0000);
        checks++; if (isIOAddrBlock !== 2'b11) begin errors++; $display("FAIL look_top got %b exp 11", isIOAddrBlock); end
        set_look(32'h0000_1000);
        checks++; if (isIOAddrBlock !== 2'b00) begin errors++; $display("FAIL look_low got %b exp 00", isIOAddrBlock); end
        // cmd_ready while idle must not complete anything
        @(negedge clk); cmd_ready = 2'b11;
        @(negedge clk); cmd_ready = 2'b00;
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h0 || cmd_valid !== 2'b00) begin errors++; $display("FAIL idle_ready got %h/%b exp 0/00", rd, cmd_valid); end
    endtask

    task automatic test_regions;
        bus_write(32'h10, 32'h0000_4000);
        bus_write(32'h14, 32'h0000_7C00);
        bus_write(32'h00, 32'h0001_0103);
        bus_read(32'h10, rd, rv);
        checks++; if (rd !== 32'h0000_4000) begin errors++; $display("FAIL low0_rd got %h exp 00004000", rd); end
        bus_read(32'h00, rd, rv);
        checks++; if (rd !== 32'h0001_0103) begin errors++; $display("FAIL ctrl_rd got %h exp 00010103", rd); end
        set_look(32'h0000_4000);
        checks++; if (isIOAddrBlock !== 2'b11) begin errors++; $display("FAIL reg_low_edge got %b exp 11", isIOAddrBlock); end
        set_look(32'h0000_7FFF);
        checks++; if (isIOAddrBlock !== 2'b11) begin errors++; $display("FAIL reg_high_edge got %b exp 11", isIOAddrBlock); end
        set_look(32'h0000_8000);
        checks++; if (isIOAddrBlock !== 2'b00) begin errors++; $display("FAIL reg_above got %b exp 00", isIOAddrBlock); end
        set_look(32'h0000_3FFF);
        checks++; if (isIOAddrBlock !== 2'b00) begin errors++; $display("FAIL reg_below got %b exp 00", isIOAddrBlock); end
        // mixed per-channel lookup
        look_addr = {32'h0000_1000, 32'h0000_5000}; #1;
        checks++; if (isIOAddrBlock !== 2'b01) begin errors++; $display("FAIL reg_mixed got %b exp 01", isIOAddrBlock); end
        bus_write(32'h00, 32'h0000_0103);
        set_look(32'h0000_4000);
        checks++; if (isIOAddrBlock !== 2'b00) begin errors++; $display("FAIL reg_disabled got %b exp 00", isIOAddrBlock); end
        // offset beyond the last region: write dropped, reads 0
        bus_write(32'h30, 32'hFFFF_FFFF);
        bus_read(32'h30, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL beyond_regions got %h exp 0", rd); end
    endtask

    task automatic test_cmd;
        bus_write(32'h04, 32'h0000_0303);
        checks++; if (cmd_valid !== 2'b11 || cmd !== 6'b011_011) begin errors++; $display("FAIL cmd_issue got %b/%b exp 11/011011", cmd_valid, cmd); end
        bus_read(32'h04, rd, rv);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL busy got %h exp 3", rd); end
        @(negedge clk); cmd_ready = 2'b01;
        @(negedge clk); cmd_ready = 2'b00;
        checks++; if (cmd_valid !== 2'b10 || cmd[5:3] !== 3'd3) begin errors++; $display("FAIL ch0_done got %b/%h exp 10/3", cmd_valid, cmd[5:3]); end
        // ch1 completes on the same edge that W1C-clears done[1]: set wins
        @(negedge clk);
        s0_address = 32'h08; s0_writeData = 32'h2; s0_write = 1'b1; cmd_ready = 2'b10;
        @(negedge clk);
        s0_write = 1'b0; cmd_ready = 2'b00;
        checks++; if (cmd_valid !== 2'b00) begin errors++; $display("FAIL ch1_done got %b exp 00", cmd_valid); end
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL status_done got %h exp 3", rd); end
        bus_write(32'h08, 32'h3);
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_w1c got %h exp 0", rd); end
        bus_read(32'h04, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL busy_idle got %h exp 0", rd); end
    endtask

    task automatic test_enable_off;
        bus_write(32'h00, 32'h0000_0102);
        checks++; if (cmd_valid !== 2'b01 || cmd[2:0] !== 3'd1) begin errors++; $display("FAIL en_off_cmd got %b/%h exp 01/1", cmd_valid, cmd[2:0]); end
        checks++; if (isEnableCache !== 2'b10) begin errors++; $display("FAIL en_off_enable got %b exp 10", isEnableCache); end
        bus_write(32'h04, 32'h0000_0201);
        checks++; if (cmd_valid !== 2'b01 || cmd[2:0] !== 3'd1) begin errors++; $display("FAIL busy_drop got %b/%h exp 01/1", cmd_valid, cmd[2:0]); end
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL status_err got %h exp 100", rd); end
        @(negedge clk); cmd_ready = 2'b01;
        @(negedge clk); cmd_ready = 2'b00;
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h101) begin errors++; $display("FAIL status_err_done got %h exp 101", rd); end
        bus_write(32'h08, 32'h101);
        bus_write(32'h00, 32'h0000_0103);
        checks++; if (cmd_valid !== 2'b00) begin errors++; $display("FAIL en_on_noreq got %b exp 00", cmd_valid); end
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_clr2 got %h exp 0", rd); end
    endtask

    task automatic test_reset_mid;
        bus_write(32'h04, 32'h0000_0102);
        checks++; if (cmd_valid !== 2'b10 || cmd[5:3] !== 3'd1) begin errors++; $display("FAIL ch1_issue got %b/%h exp 10/1", cmd_valid, cmd[5:3]); end
        #2 rest = 1'b0;
        #1;
        checks++; if (cmd_valid !== 2'b00 || cmd !== 6'd0) begin errors++; $display("FAIL async_reset got %b/%h exp 00/0", cmd_valid, cmd); end
        @(negedge clk); rest = 1'b1;
        bus_read(32'h08, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_after_rst got %h exp 0", rd); end
        bus_read(32'h00, rd, rv);
        checks++; if (rd !== 32'h103) begin errors++; $display("FAIL ctrl_after_rst got %h exp 103", rd); end
    endtask

    initial begin
        test_reset;
        test_regions;
        test_cmd;
        test_enable_off;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_region_ctr.md
# cache_region_ctr

Memory-mapped control block for the cache subsystem, the parametrised successor to the single-channel cache control register. It holds a configurable number of uncached/IO address regions at configurable boundary granularity, and per-channel cache enables. It drives an independent maintenance-command handshake (invalidate / writeback / both) to each of `CMD_CH` cache channels and reports busy, done and error status. It sits on the s0 slave bus beside the caches and answers the per-channel "is this address IO" lookup combinationally.

## Interface
- `REGION_NUM`, 4 — number of IO regions, 1..16
- `GRAN_BITS`, 10 — region boundary granularity; boundaries store `addr[31:GRAN_BITS]`
- `CMD_CH`, 2 — number of cache channels (for example I$ and D$), 1..8
- `clk`  in  1  clock
- `rest`  in  1  reset; asynchronous, active-low
- `s0_address`  in  32  byte address; word-indexed by `[7:2]`
- `s0_byteEnable`  in  4  ignored; all accesses are full-word
- `s0_read`  in  1  read strobe
- `s0_readData`  out  32  read data
- `s0_write`  in  1  write strobe
- `s0_writeData`  in  32  write data
- `s0_waitRequest`  out  1  tied to 0
- `s0_readDataValid`  out  1  read data valid
- `look_addr`  in  32*CMD_CH  per-channel lookup address
- `isIOAddrBlock`  out  CMD_CH  per-channel IO hit
- `isEnableCache`  out  CMD_CH  per-channel cache enable
- `cmd`  out  3*CMD_CH  per-channel command code
- `cmd_valid`  out  CMD_CH  per-channel command valid
- `cmd_ready`  in  CMD_CH  per-channel command accept

## Operation
Register map. Unimplemented bits read 0. Offsets above the last region read 0; writes to them are dropped.
- 0x00 CTRL (RW)
  - `[CMD_CH-1:0]` cache enable; reset all 1.
  - `[8]` top-half IO (`addr[31]`=1 is IO); reset 1.
  - `[16+i]` region i enable; reset 0.
- 0x04 CMD
  - Write: `[CMD_CH-1:0]` channel mask, `[9:8]` op. Op bit0 = invalidate, bit1 = writeback; op 0 is a no-op.
  - Read: `[CMD_CH-1:0]` busy.
- 0x08 STATUS
  - `[CMD_CH-1:0]` done (sticky).
  - `[8+CMD_CH-1:8]` err (sticky).
  - Write-1-to-clear.
- 0x10+8i LOW_i, 0x14+8i HIGH_i (RW), bits `[31:GRAN_BITS]`.
  - Reset: LOW = all ones, HIGH = 0.
  - Low bits read 0.

IO lookup (combinational), per channel c: `isIOAddrBlock[c]` = (CTRL[8] & look_addr[c][31]) OR any enabled region i with LOW_i ≤ look_addr[c][31:GRAN_BITS] ≤ HIGH_i. The comparison is unsigned.

Command requests, per channel:
- A CMD write with mask bit c set and op≠0 requests op.
- A CTRL write that changes enable[c] from 1 to 0 requests invalidate. Enable-off must flush stale lines.
- Both in the same cycle: the ops are ORed. Codes: 1 → `cache_io_cmd_clear`, 2 → `cache_io_cmd_wb`, 3 → `cache_io_cmd_wbclear`.
- A request to a channel that is not IDLE is dropped and sets err[c]. Other channels in the mask proceed normally.

Per-channel FSM:
- IDLE → on a request: `cmd_valid`=1, `cmd` latched → WAIT.
- WAIT → on `cmd_ready` → IDLE, `cmd_valid`=0, done[c] set.
- busy[c] = (state ≠ IDLE).

Simultaneous events:
- Done or err set in the same cycle as a W1C write to the same bit: set wins.
- Reset mid-command: channel goes to IDLE, `cmd_valid` drops asynchronously, and no done bit is set.

## Timing
- Reset values: `s0_readData`=0, `s0_readDataValid`=0, `cmd_valid`=0, `cmd`=0. `isEnableCache` = all 1. `isIOAddrBlock` follows the reset registers, so a lookup address with bit 31 set is IO and all others are not.
- Read: registered. Data and `s0_readDataValid` appear 1 cycle after `s0_read`. Back-to-back reads are allowed.
- Write: takes effect at the next edge. Lookup outputs reflect it in the following cycle.
- Command issue:
  - `cmd_valid` rises 1 cycle after the triggering write.
  - `cmd` is stable while `cmd_valid`=1.
  - The handshake completes on the edge where `cmd_valid` & `cmd_ready` are both 1.
  - `cmd_valid` is low the next cycle.
  - Minimum spacing between commands on one channel: 2 cycles.
- `cmd_ready` asserted while `cmd_valid`=0 is ignored.

## Structure
- Shared package `cache_pkg`:
  - op encodings and 3-bit `cmd` codes, including a new `cache_io_cmd_wbclear`
  - register offset constants
  - channel FSM state enum
- Sub-module `cache_cmd_chan`:
  - one per channel, generate-instantiated
  - inputs: `req`, `op`, `cmd_ready`
  - outputs: `cmd`, `cmd_valid`, `busy`, `done_pulse`, `err_pulse`
- Top level holds the register file, the region comparators and the STATUS logic.

## Test plan
- Reset, then read 0x00 → `0x0000_0103` (CMD_CH=2). Read 0x14 → 0. `look_addr`=0x8000_0000 → `isIOAddrBlock`=1. `look_addr`=0x0000_1000 → 0.
- Write LOW_0=0x0000_4000, HIGH_0=0x0000_7C00, CTRL=0x0001_0103:
  - 0x4000 → IO; 0x7FFF → IO; 0x8000 → not IO.
  - Region enable cleared → 0x4000 not IO.
- Write CMD=0x0000_0303:
  - Both channels show `cmd`=wbclear, `cmd_valid`=1 one cycle later; busy=0x3.
  - `cmd_ready[0]` after 3 cycles, `cmd_ready[1]` after 5.
  - STATUS = 0x3; writing 0x3 to STATUS clears it to 0.
- Write CTRL=0x102 (ch0 enable 1→0) → ch0 `cmd`=clear, `isEnableCache`=2'b10. The same write combined with CMD op=wb in an adjacent cycle while busy → err[0] set, STATUS[8]=1.
- Assert `rest` low while ch1 is in WAIT → `cmd_valid[1]`=0 immediately, STATUS reads 0 after reset.
